// File: rtl/primus_core_pkg.sv
// Shared types and constants for the primus core front end.
package primus_core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] npc;
    } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with push/pop/clear and occupancy count; clear wins over push and pop.
module if_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o    = (r_count == CW'(DEPTH));
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign rdata_o   = r_mem[r_rd_ptr];
    assign w_push_ok = push_i && !full_o;
    assign w_pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= f_inc(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= f_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    // Storage needs no reset: the head is only meaningful while not empty.
    always_ff @(posedge clk_i) begin
        if (w_push_ok && !clear_i) r_mem[r_wr_ptr] <= wdata_i;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, response buffer, redirect drain.
// Optional feature macro: PRIMUS_IF_MISALIGN_EN (flag misaligned redirects and stop fetching).
module if_stage
    import primus_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] npc_o,
    output logic        instr_misaligned_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    if_state_e     r_state;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;

    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_out_next;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_credit;
    logic          w_grant;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic          w_misaligned;
    logic [31:0]   w_resp_pc;
    logic [31:0]   w_redirect_pc;
    if_entry_t     w_push_entry;
    if_entry_t     w_head;

    // Credit uses registered counts only, so a same-cycle pop frees nothing yet.
    assign w_credit    = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < SW'(FIFO_DEPTH);
    assign imem_req_o  = (r_state == FETCH) && !redirect_i && w_credit && !w_fifo_full
                         && !w_misaligned;
    assign imem_addr_o = r_pc;

    assign w_grant    = imem_req_o && imem_gnt_i;
    assign w_resp     = imem_rvalid_i && (r_outstanding != '0);
    assign w_out_next = r_outstanding + CW'(w_grant) - CW'(w_resp);

    // Outstanding requests in FETCH are the consecutive words just below r_pc.
    assign w_resp_pc          = r_pc - 32'({r_outstanding, 2'b00});
    assign w_push_entry.instr = imem_rdata_i;
    assign w_push_entry.npc   = w_resp_pc + 32'd4;
    assign w_push             = w_resp && (r_state == FETCH) && !redirect_i;
    assign w_pop              = if_valid_o && id_ready_i;
    assign w_redirect_pc      = redirect_pc_i & 32'hFFFF_FFFC;

    assign if_valid_o = !w_fifo_empty;
    assign instr_o    = w_fifo_empty ? NOP_INSTR : w_head.instr;
    assign npc_o      = w_fifo_empty ? 32'd0 : w_head.npc;

    if_fifo #(
        .WIDTH ($bits(if_entry_t)),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .wdata_i (w_push_entry),
        .pop_i   (w_pop),
        .clear_i (redirect_i),
        .rdata_o (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_i) begin
                r_pc <= w_redirect_pc;
            end else if (w_grant) begin
                r_pc <= r_pc + 32'd4;
            end
            case (r_state)
                BOOT:    r_state <= FETCH;
                FETCH:   if (redirect_i && ((r_outstanding != '0) || w_grant)) r_state <= DRAIN;
                DRAIN:   if (w_out_next == '0) r_state <= FETCH;
                default: r_state <= BOOT;
            endcase
        end
    end

`ifdef PRIMUS_IF_MISALIGN_EN
    logic r_misaligned;

    // Sticky until the next redirect re-evaluates it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_misaligned <= 1'b0;
        end else if (redirect_i) begin
            r_misaligned <= |redirect_pc_i[1:0];
        end
    end

    assign w_misaligned       = r_misaligned;
    assign instr_misaligned_o = r_misaligned;
`else
    assign w_misaligned       = 1'b0;
    assign instr_misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomised scoreboard bench for if_stage: memory model, expected-instruction queue, monitor.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 3;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic        id_ready_i;
    logic [31:0] instr_o;
    logic [31:0] npc_o;
    logic        instr_misaligned_o;

    if_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .imem_req_o         (imem_req_o),
        .imem_addr_o        (imem_addr_o),
        .imem_gnt_i         (imem_gnt_i),
        .imem_rvalid_i      (imem_rvalid_i),
        .imem_rdata_i       (imem_rdata_i),
        .redirect_i         (redirect_i),
        .redirect_pc_i      (redirect_pc_i),
        .if_valid_o         (if_valid_o),
        .id_ready_i         (id_ready_i),
        .instr_o            (instr_o),
        .npc_o              (npc_o),
        .instr_misaligned_o (instr_misaligned_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    exp_t        q[$];
    mem_t        mem[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          pops = 0;
    logic [31:0] model_pc;
    int          drop_pending;
    int          settle;
    bit          mis_model;
    int          gnt_pct, ready_pct, redir_pct, max_delay;
    bit          force_redir;
    logic [31:0] force_target;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req",   32'(imem_req_o), 32'd0);
        chk("rst_addr",  imem_addr_o, RESET_PC);
        chk("rst_valid", 32'(if_valid_o), 32'd0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_npc",   npc_o, 32'd0);
        chk("rst_mis",   32'(instr_misaligned_o), 32'd0);
    endtask

    task automatic model_reset();
        q.delete();
        mem.delete();
        model_pc     = RESET_PC;
        drop_pending = 0;
        settle       = 0;
        mis_model    = 1'b0;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(3))
            0:       t = $urandom & 32'h0000_0FFC;
            1:       t = 32'hFFFF_FFF0 + (32'($urandom_range(3)) << 2);
            2:       t = $urandom & 32'h0000_FFFF;
            default: t = $urandom;
        endcase
        return t;
    endfunction

    // One clock of stimulus plus the reference model's view of the coming edge.
    task automatic cycle();
        logic [31:0] tgt;
        bit          decided;
        bit          exp_req;
        @(negedge clk);
        tgt = 32'd0;
        id_ready_i = ($urandom_range(99) < 32'(ready_pct));
        imem_gnt_i = ($urandom_range(99) < 32'(gnt_pct));
        if (force_redir) begin
            tgt         = force_target;
            force_redir = 1'b0;
            redirect_i  = 1'b1;
        end else if ($urandom_range(99) < 32'(redir_pct)) begin
            tgt        = rand_target();
            redirect_i = 1'b1;
        end else begin
            redirect_i = 1'b0;
        end
        redirect_pc_i = redirect_i ? tgt : $urandom;
        if (mem.size() > 0 && mem[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        #1;
        if (settle > 0) settle--;

        chk("misaligned", 32'(instr_misaligned_o), 32'(mis_model));
        if (imem_req_o) chk("req_addr", imem_addr_o, model_pc);

        decided = 1'b0;
        exp_req = 1'b0;
        if (redirect_i || drop_pending > 0 || mis_model || q.size() >= DEPTH) begin
            decided = 1'b1;
        end else if (settle == 0) begin
            decided = 1'b1;
            exp_req = 1'b1;
        end
        if (decided) chk("req", 32'(imem_req_o), 32'(exp_req));

        if (imem_rvalid_i) begin
            void'(mem.pop_front());
            if (drop_pending > 0) begin
                drop_pending--;
                settle = 2;
            end
        end
        if (imem_req_o && imem_gnt_i) begin
            mem.push_back('{addr: model_pc, due: cyc + 1 + $urandom_range(max_delay)});
            q.push_back('{instr: mem_word(model_pc), npc: model_pc + 32'd4});
            model_pc = model_pc + 32'd4;
        end
        if (redirect_i) begin
            drop_pending = mem.size();
            q.delete();
            model_pc = tgt & 32'hFFFF_FFFC;
`ifdef PRIMUS_IF_MISALIGN_EN
            mis_model = |tgt[1:0];
`else
            mis_model = 1'b0;
`endif
            settle = 2;
        end
        cyc++;
    endtask

    // Monitor: every delivered instruction must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_ni) begin
            if (if_valid_o) begin
                if (id_ready_i && !redirect_i) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_pop: got npc %h expected no entry (cycle %0d)",
                                 npc_o, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("instr", instr_o, e.instr);
                        chk("npc", npc_o, e.npc);
                        pops++;
                    end
                end
            end else begin
                chk("empty_instr", instr_o, NOP);
                chk("empty_npc", npc_o, 32'd0);
            end
        end
    end

    initial begin
        int p0;
        rst_ni        = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        id_ready_i    = 1'b0;
        force_redir   = 1'b0;
        force_target  = 32'd0;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_ni = 1'b1;
        #1 chk("boot_req", 32'(imem_req_o), 32'd0);

        // Zero-wait memory: one instruction per cycle after fill.
        gnt_pct = 100; ready_pct = 100; redir_pct = 0; max_delay = 0;
        repeat (10) cycle();
        p0 = pops;
        repeat (20) cycle();
        chk("throughput", 32'(pops - p0), 32'd20);

        // Decode stall: requests stop once the buffer credit is used.
        ready_pct = 0;
        repeat (12) cycle();
        chk("stall_req", 32'(imem_req_o), 32'd0);
        chk("stall_valid", 32'(if_valid_o), 32'd1);
        ready_pct = 100;
        repeat (5) cycle();

        // Grant withheld: address must stay put.
        gnt_pct = 0;
        repeat (4) cycle();
        gnt_pct = 100;
        repeat (5) cycle();

        // Redirect with responses in flight.
        max_delay = 3;
        repeat (6) cycle();
        force_redir = 1'b1; force_target = 32'h0000_0100;
        repeat (12) cycle();
        max_delay = 0;

        // Misaligned redirect, then recover.
        force_redir = 1'b1; force_target = 32'h0000_0102;
        repeat (15) cycle();
        force_redir = 1'b1; force_target = 32'h0000_0200;
        repeat (10) cycle();

        // PC wrap past the top of the address space.
        force_redir = 1'b1; force_target = 32'hFFFF_FFF4;
        repeat (12) cycle();

        // Randomised traffic.
        gnt_pct = 75; ready_pct = 70; redir_pct = 3; max_delay = 2;
        repeat (3000) cycle();

        // Asynchronous reset mid-operation.
        @(negedge clk);
        #3 rst_ni = 1'b0;
        #1 check_reset_outputs();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        redirect_i    = 1'b0;
        id_ready_i    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #1 chk("boot_req2", 32'(imem_req_o), 32'd0);
        gnt_pct = 100; ready_pct = 100; redir_pct = 0; max_delay = 0;
        repeat (20) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage of the primus RISC-V core. Holds the program counter, issues word requests to instruction memory over a request/grant/rvalid handshake, and buffers returned instructions in a small FIFO. It feeds `instr`/`npc` pairs to `id_stage` through a valid/ready handshake. Branch/jump redirects from later stages flush the buffer and discard in-flight responses.

## Interface
Parameters:
- `RESET_PC`: default 32'h0000_0000. First fetch address after reset.
- `FIFO_DEPTH`: default 3. Instruction buffer entries and the credit limit for outstanding requests. Must be ≥ 2.

Ports:
- `clk_i` in, 1: single clock, rising edge.
- `rst_ni` in, 1: asynchronous active-low reset.
- `imem_req_o` out, 1: fetch request.
- `imem_addr_o` out, 32: word-aligned fetch address.
- `imem_gnt_i` in, 1: request accepted this cycle.
- `imem_rvalid_i` in, 1: response data valid. Responses arrive in order.
- `imem_rdata_i` in, 32: instruction word.
- `redirect_i` in, 1: branch/jump taken.
- `redirect_pc_i` in, 32: redirect target.
- `if_valid_o` out, 1: FIFO head is valid.
- `id_ready_i` in, 1: `id_stage` accepts the head.
- `instr_o` out, 32: head instruction. Reads 32'h0000_0013 (NOP) when empty.
- `npc_o` out, 32: head fetch address + 4. Reads 0 when empty.
- `instr_misaligned_o` out, 1: misaligned redirect flag. See Configuration.

## Operation
- States:
  - BOOT: one cycle after reset release; no request.
  - FETCH: normal operation.
  - DRAIN: discarding stale responses.
- State transitions:
  - BOOT→FETCH unconditionally.
  - FETCH→DRAIN on redirect while `outstanding` > 0 (counting a request granted that same cycle).
  - FETCH stays FETCH on redirect when nothing is outstanding.
  - DRAIN→FETCH when `outstanding` reaches 0.
  - A redirect during DRAIN updates `pc_q` and stays in DRAIN.
- Request issue:
  - `imem_req_o` = state==FETCH && !redirect_i && (fifo_count + outstanding < FIFO_DEPTH).
  - Credit uses registered counts; a pop in the same cycle does not add credit.
  - `imem_addr_o` = `pc_q`. On `req && gnt`, `pc_q += 4` and `outstanding++`.
  - While `req && !gnt`, the address is held stable.
  - A redirect may withdraw an ungranted request.
- Response:
  - On `rvalid` in FETCH: push {rdata, issue address + 4}. The issue address comes from an internal address queue or a tag counter. Then `outstanding--`.
  - In DRAIN: `rvalid` decrements `outstanding` and its data is dropped.
- Pop: `if_valid_o && id_ready_i` removes the head.
- Redirect: FIFO cleared the same edge and `pc_q` ← target; it overrides a same-cycle pop and a same-cycle push.
- Arithmetic: PC is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0). Counters are $clog2(FIFO_DEPTH+1) bits wide and never over- or underflow.

## Timing
- Reset values:
  - `imem_req_o` 0, `imem_addr_o` RESET_PC.
  - `if_valid_o` 0, `instr_o` NOP, `npc_o` 0.
  - `instr_misaligned_o` 0.
  - State BOOT, all counters 0.
- First request is driven on the second rising edge after `rst_ni` deasserts.
- FIFO is registered with no bypass: `if_valid_o` rises the cycle after `rvalid`.
- With a zero-wait memory (gnt same cycle, rvalid next), the default depth sustains one instruction per cycle.
- Reset asserted mid-operation returns everything to reset values immediately. Responses from before reset are the memory's responsibility.

## Configuration
- `PRIMUS_IF_MISALIGN_EN` defined:
  - A redirect with `redirect_pc_i[1:0] != 0` sets `instr_misaligned_o` (sticky until the next redirect or reset).
  - Fetching stops: no requests while the flag is set.
- Undefined:
  - `redirect_pc_i[1:0]` is forced to 00.
  - `instr_misaligned_o` is tied 0.

## Structure
- `primus_core_pkg` gains:
  - `if_state_e` (BOOT, FETCH, DRAIN).
  - `NOP_INSTR` = 32'h0000_0013.
  - `RESET_PC_DEFAULT`.
  - `if_entry_t` {instr, npc}.
- One sub-module, `if_fifo`: a parameterised synchronous FIFO with push, pop, clear, full, empty and count.

## Test plan
- Reset release with memory returning `rdata = addr` and id_ready=1 → requests at 0, 4, 8, …; ID sees (instr 0x0, npc 0x4), (0x4, 0x8), …; one per cycle after fill.
- id_ready=0 for 10 cycles → exactly 3 requests issued, then `req` low; FIFO holds npc 4, 8, C, all released in order when ready returns.
- `gnt` delayed 3 cycles on address 0x8 → `imem_addr_o` stays 0x8 throughout; no duplicate entries.
- Redirect to 0x100 with 2 responses outstanding → FIFO empty next cycle; 2 `rvalid`s dropped in DRAIN; next valid is (instr 0x100, npc 0x104).
- Redirect same cycle as a pop and an rvalid → neither entry is delivered; state, counters and target are correct.
- With `PRIMUS_IF_MISALIGN_EN`, redirect to 0x102 → `instr_misaligned_o`=1 and no further requests. Without the macro, the same redirect fetches from 0x100.
